// File: rtl/operand_loader_if.sv
// operand_loader_if: switch/key inputs and captured operand outputs of operand_loader.
//   N            operand width; A/B are N bits wide
//   SW[9:0]      SW[N-1:0] operand value, SW[9:8] function code
//   KEY          step push-button, active-low, asynchronous
//   A, B, F      captured operands and function code
//   valid        complete operand set present
//   load_strobe  one-cycle pulse after each capture
//   state        FSM state code for LEDG
// Modports: master drives SW/KEY (switch board side), slave is the loader.
interface operand_loader_if #(
  parameter int N = 4
);
  logic [9:0]   SW;
  logic         KEY;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic [1:0]   F;
  logic         valid;
  logic         load_strobe;
  logic [1:0]   state;

  modport master (
    output SW, KEY,
    input  A, B, F, valid, load_strobe, state
  );

  modport slave (
    input  SW, KEY,
    output A, B, F, valid, load_strobe, state
  );
endinterface

// File: rtl/operand_loader.sv
// operand_loader: input front end for the 4-bit logic unit. Captures operand A, operand B and
// function F from SW, one item per KEY press, through a synchronized, debounced step FSM.
// Ports:
//   CLOCK_50  system clock, all state on the rising edge
//   reset     asynchronous active-high reset
//   bus       operand_loader_if.slave (SW, KEY in; A, B, F, valid, load_strobe, state out)
// Parameters:
//   N                operand width, 1..8 (SW[9:8] holds F, so wider operands would overlap)
//   DEBOUNCE_CYCLES  cycles the synced key level must differ from the stable level before it
//                    is accepted
// Build option: define DEBOUNCE_EN to include the debouncer. Without it the stable level is
// the synchronizer output and DEBOUNCE_CYCLES is ignored.
module operand_loader #(
  parameter int          N               = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic              CLOCK_50,
  input logic              reset,
  operand_loader_if.slave  bus
);

  if (N < 1 || N > 8) begin : g_bad_n
    $error("operand_loader: N must be in 1..8 so SW[9:8] stays free for F");
  end

  typedef enum logic [1:0] {
    StLoadA = 2'b00,
    StLoadB = 2'b01,
    StLoadF = 2'b10,
    StRun   = 2'b11
  } state_e;

  // Key synchronizer; reset value 1 is the released level.
  logic sync1_q, sync2_q;
  logic stable;
  logic stable_prev_q;
  logic press;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= bus.KEY;
      sync2_q <= sync1_q;
    end
  end

`ifdef DEBOUNCE_EN
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("operand_loader: DEBOUNCE_CYCLES must be at least 1");
  end

  localparam int CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q;
  logic            stable_q;

  // The counter only runs while the synced level disagrees with the accepted one; any
  // agreeing cycle restarts it, so short glitches never reach the stable level.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else if (sync2_q == stable_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      stable_q <= sync2_q;
      cnt_q    <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign stable = stable_q;
`else
  localparam int unsigned unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable = sync2_q;
`endif

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      stable_prev_q <= 1'b1;
    end else begin
      stable_prev_q <= stable;
    end
  end

  // Falling edge of the stable level only; release makes no pulse.
  assign press = stable_prev_q & ~stable;

  state_e         state_q, state_d;
  logic [N-1:0]   a_q, a_d, b_q, b_d;
  logic [1:0]     f_q, f_d;
  logic           valid_q, valid_d;
  logic           strobe_q;
  logic           capture;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    f_d     = f_q;
    valid_d = valid_q;
    capture = 1'b0;
    if (press) begin
      unique case (state_q)
        StLoadA: begin
          a_d     = bus.SW[N-1:0];
          valid_d = 1'b0;
          capture = 1'b1;
          state_d = StLoadB;
        end
        StLoadB: begin
          b_d     = bus.SW[N-1:0];
          capture = 1'b1;
          state_d = StLoadF;
        end
        StLoadF: begin
          f_d     = bus.SW[9:8];
          valid_d = 1'b1;
          capture = 1'b1;
          state_d = StRun;
        end
        StRun: begin
          valid_d = 1'b0;
          state_d = StLoadA;
        end
        default: state_d = StLoadA;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= StLoadA;
      a_q      <= '0;
      b_q      <= '0;
      f_q      <= '0;
      valid_q  <= 1'b0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      f_q      <= f_d;
      valid_q  <= valid_d;
      strobe_q <= capture;
    end
  end

  assign bus.A           = a_q;
  assign bus.B           = b_q;
  assign bus.F           = f_q;
  assign bus.valid       = valid_q;
  assign bus.load_strobe = strobe_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_operand_loader.sv
module tb_operand_loader;

`ifdef DEBOUNCE_EN
  localparam int D = 4;
`else
  localparam int D = 0;
`endif

  typedef struct {
    int         cyc;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] f;
    logic       v;
    logic [1:0] st;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   passed = 0;
  int   strobes = 0;
  exp_t sb_q[$];

  operand_loader_if #(.N(4)) bus ();

  operand_loader #(
    .N              (4),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  // Monitor: every load_strobe must match the oldest queued expectation, cycle included.
  always @(negedge clk) begin
    if (!reset && bus.load_strobe === 1'b1) begin
      strobes++;
      if (sb_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_strobe: got strobe at cycle %0d expected none", cyc);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("strobe_cycle", cyc, e.cyc);
        chk("strobe_A", bus.A, e.a);
        chk("strobe_B", bus.B, e.b);
        chk("strobe_F", bus.F, e.f);
        chk("strobe_valid", bus.valid, e.v);
        chk("strobe_state", bus.state, e.st);
      end
    end
  end

  // Press the key; when cap is set, queue the state expected right after the capture edge.
  task automatic press(input logic [9:0] sw, input int hold, input logic cap,
                       input logic [3:0] ea, input logic [3:0] eb, input logic [1:0] ef,
                       input logic ev, input logic [1:0] es);
    exp_t e;
    @(posedge clk); #1;
    bus.SW  = sw;
    bus.KEY = 1'b0;
    if (cap) begin
      e = '{cyc: cyc + 3 + D, a: ea, b: eb, f: ef, v: ev, st: es};
      sb_q.push_back(e);
    end
    repeat (hold) @(posedge clk);
    #1 bus.KEY = 1'b1;
    repeat (D + 8) @(posedge clk);
    #1 bus.SW = ~sw;
  endtask

  task automatic check_regs(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                            input logic [1:0] ef, input logic ev, input logic [1:0] es);
    chk({tag, "_A"}, bus.A, ea);
    chk({tag, "_B"}, bus.B, eb);
    chk({tag, "_F"}, bus.F, ef);
    chk({tag, "_valid"}, bus.valid, ev);
    chk({tag, "_state"}, bus.state, es);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.SW  = 10'h000;
    bus.KEY = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_regs("reset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
    chk("reset_strobe", bus.load_strobe, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // Reset during a pending press: outputs clear at once and the press is lost.
    @(posedge clk); #1;
    bus.SW  = 10'h007;
    bus.KEY = 1'b0;
    repeat (2 + D / 2) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check_regs("midreset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
    chk("midreset_strobe", bus.load_strobe, 1'b0);
    bus.KEY = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (D + 8) @(posedge clk);
    #1;
    check_regs("postreset", 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);

    // Full load.
    press(10'h003, D + 2, 1'b1, 4'h3, 4'h0, 2'b00, 1'b0, 2'b01);
    press(10'h005, D + 2, 1'b1, 4'h3, 4'h5, 2'b00, 1'b0, 2'b10);
    press(10'h200, D + 2, 1'b1, 4'h3, 4'h5, 2'b10, 1'b1, 2'b11);

    // Switch changes alone never reach the outputs.
    bus.SW = 10'h3FF;
    repeat (6) @(posedge clk);
    #1;
    check_regs("sw_noise", 4'h3, 4'h5, 2'b10, 1'b1, 2'b11);

`ifdef DEBOUNCE_EN
    // Glitch one cycle shorter than the debounce window.
    @(posedge clk); #1;
    bus.SW  = 10'h00F;
    bus.KEY = 1'b0;
    repeat (D - 1) @(posedge clk);
    #1 bus.KEY = 1'b1;
    repeat (D + 8) @(posedge clk);
    #1;
    check_regs("glitch", 4'h3, 4'h5, 2'b10, 1'b1, 2'b11);
`endif

    // Wrap: press in RUN captures nothing.
    press(10'h001, D + 2, 1'b0, 4'h0, 4'h0, 2'b00, 1'b0, 2'b00);
    check_regs("wrap", 4'h3, 4'h5, 2'b10, 1'b0, 2'b00);
    press(10'h00A, D + 2, 1'b1, 4'hA, 4'h5, 2'b10, 1'b0, 2'b01);

    // Long hold gives a single capture; a fresh press captures again.
    press(10'h00C, 20, 1'b1, 4'hA, 4'hC, 2'b10, 1'b0, 2'b10);
    press(10'h300, D + 2, 1'b1, 4'hA, 4'hC, 2'b11, 1'b1, 2'b11);

    for (int i = 0; i < 50 && sb_q.size() != 0; i++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb_q.size(), 0);
    chk("strobe_count", strobes, 6);
    check_regs("final", 4'hA, 4'hC, 2'b11, 1'b1, 2'b11);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
